seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-anode multi-digit seven-segment display.
- Writers load a full frame of hex nibbles, digit-enable and decimal-point bits through a valid/ready port.
- The block cycles one shared segment decoder across all digits with a fixed dwell time and an anti-ghosting blank interval.
- New frames take effect only at frame boundaries, so the display never shows a partial update.

Parameters:
- NDIG, 4, number of digits scanned (1..8).
- DIV, 1000, clock cycles per digit slot (DIV >= BLANK+1).
- BLANK, 16, cycles at the start of each slot during which all anodes are off (BLANK >= 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  writer presents a new frame.
- wr_ready  out  1  block can accept a frame (= pending buffer empty).
- wr_data  in  4*NDIG  hex nibble per digit; digit i = wr_data[4i+3:4i].
- wr_en  in  NDIG  per-digit enable; 0 = digit dark.
- wr_dp  in  NDIG  per-digit decimal point; 1 = lit.
- seg_out  out  8  active-low segments, bit7=a .. bit1=g, bit0=dp.
- an_out  out  NDIG  active-low anode selects.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Registers:
  - active frame: data, en, dp.
  - pending frame: data, en, dp, plus pend_valid.
  - slot counter cnt: 0..DIV-1.
  - digit index idx: 0..NDIG-1.
  - phase state BLANK/SHOW.
- Reset (async, immediate):
  - active and pending cleared; pend_valid=0.
  - cnt=0, idx=0, state=BLANK.
  - seg_out=8'hFF, an_out=all 1s, frame_done=0.
  - wr_ready=1, including while rst is held.
- Handshake:
  - wr_ready = !pend_valid.
  - Transfer occurs when wr_valid && wr_ready at a rising edge.
  - Accepted data goes to pending and sets pend_valid.
  - wr_valid is ignored while wr_ready=0.
- Counting:
  - cnt increments every cycle and wraps DIV-1 -> 0.
  - On wrap, idx increments, wrapping NDIG-1 -> 0.
  - The cycle in which (cnt, idx) becomes (0, 0) after a wrap is the frame boundary.
- FSM:
  - BLANK while cnt < BLANK.
  - SHOW while BLANK <= cnt <= DIV-1.
  - BLANK -> SHOW when cnt reaches BLANK.
  - SHOW -> BLANK on slot wrap.
- Outputs (registered, glitch-free; in the cycle cnt==k, outputs correspond to cnt==k):
  - BLANK: an_out all 1s, seg_out=8'hFF.
  - SHOW with active en[idx]=1: an_out = ~(1<<idx).
  - SHOW with active en[idx]=1: seg_out = ~{glyph(nibble[idx]), dp[idx]}.
  - SHOW with en[idx]=0: an_out all 1s, seg_out=8'hFF.
- Glyph table, active-high abcdefg in bits 7:1:
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0.
  - 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E.
  - The dp bit is ORed into bit0 before inversion.
  - Example: digit 0 with dp off -> seg_out=8'h03.
- Frame boundary:
  - frame_done=1 for exactly that cycle.
  - If pend_valid, copy pending to active and clear pend_valid; the new frame is visible from digit 0 of this frame.
- Simultaneous events:
  - A write accepted in the boundary cycle while pend_valid=0 lands in pending, not active. It is displayed from the next boundary.
  - An accept and a copy never coincide, because an accept requires pend_valid=0.
- Reset mid-scan: the display goes dark immediately and the scan restarts at digit 0, cnt 0. Pending data is lost.
- NDIG=1: every slot wrap is a frame boundary.

Test Plan:
1. Reset, NDIG=4/DIV=8/BLANK=2, wr_valid=0:
   - wr_ready=1, seg_out=8'hFF, an_out=4'hF throughout.
   - frame_done pulses every 32 cycles.
2. Write data=16'h3210, en=4'hF, dp=4'b0100 mid-frame:
   - wr_ready drops the next cycle.
   - After the next frame_done: slot0 SHOW shows an_out=4'b1110, seg_out=8'h03.
   - slot2 shows seg_out=8'h24 (glyph DA with dp lit, inverted).
   - Each slot's first 2 cycles are 8'hFF / 4'hF.
   - wr_ready returns to 1 at the boundary.
3. Second write while pending full:
   - wr_valid held with different data; no transfer until the boundary.
   - The first frame is displayed first, the second from the following boundary.
4. Write presented in the frame_done cycle with pend_valid=0:
   - Accepted; the current frame still shows old data.
   - The new data appears only after the next frame_done.
5. en=4'b1010, data=16'hFEDC:
   - Slots 0 and 2 stay dark for the whole SHOW phase.
   - Slot1 seg_out=8'h85 (~7A), slot3 seg_out=8'h71 (~8E).
6. Assert rst during slot2 SHOW:
   - Outputs dark in the same cycle.
   - After release, the first SHOW is slot0 with cleared data (en=0 -> dark).
   - frame_done is next seen 32 cycles after release.

Source files
------------

// File: rtl/seg_scan_if.sv
// Frame-write port of the seven-segment scan controller.
// The writer drives a whole frame; the block answers with wr_ready.
interface seg_scan_if #(
    parameter int NDIG = 4
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [4*NDIG-1:0]     wr_data;
    logic [NDIG-1:0]       wr_en;
    logic [NDIG-1:0]       wr_dp;

    modport master (output wr_valid, wr_data, wr_en, wr_dp, input  wr_ready);
    modport slave  (input  wr_valid, wr_data, wr_en, wr_dp, output wr_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scanner with a double-buffered
// frame: writes land in a pending buffer and are promoted only at frame boundaries.
module seg_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DIV   = 1000,
    parameter int BLANK = 16
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_if.slave         wr,
    output logic [7:0]        seg_out,
    output logic [NDIG-1:0]   an_out,
    output logic              frame_done
);
    localparam int CW = (DIV  > 1) ? $clog2(DIV)  : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef struct packed {
        logic [4*NDIG-1:0] data;
        logic [NDIG-1:0]   en;
        logic [NDIG-1:0]   dp;
    } frame_t;

    typedef enum logic {ST_BLANK, ST_SHOW} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    frame_t          act_q, act_d;
    frame_t          pend_q, pend_d;
    logic            pend_valid_q, pend_valid_d;
    logic [7:0]      seg_q, seg_d;
    logic [NDIG-1:0] an_q, an_d;
    logic            fd_q, fd_d;

    logic            slot_wrap, frame_wrap, accept, show;
    logic [3:0]      nib;

    // Active-high abcdefg in bits 7:1; bit 0 is left for the decimal point.
    function automatic logic [7:0] glyph(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0: g = 8'hFC;  4'h1: g = 8'h60;  4'h2: g = 8'hDA;  4'h3: g = 8'hF2;
            4'h4: g = 8'h66;  4'h5: g = 8'hB6;  4'h6: g = 8'hBE;  4'h7: g = 8'hE0;
            4'h8: g = 8'hFE;  4'h9: g = 8'hF6;  4'hA: g = 8'hEE;  4'hB: g = 8'h3E;
            4'hC: g = 8'h9C;  4'hD: g = 8'h7A;  4'hE: g = 8'h9E;  default: g = 8'h8E;
        endcase
        return g;
    endfunction

    assign wr.wr_ready = !pend_valid_q;
    assign accept      = wr.wr_valid && !pend_valid_q;

    always_comb begin
        slot_wrap    = (cnt_q == CW'(DIV - 1));
        frame_wrap   = slot_wrap && (idx_q == IW'(NDIG - 1));
        cnt_d        = slot_wrap ? '0 : cnt_q + CW'(1);
        idx_d        = idx_q;
        state_d      = state_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;

        if (slot_wrap)
            idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);

        case (state_q)
            ST_BLANK: if (cnt_d == CW'(BLANK)) state_d = ST_SHOW;
            ST_SHOW:  if (slot_wrap)           state_d = ST_BLANK;
            default:                           state_d = ST_BLANK;
        endcase

        // Promotion and acceptance are mutually exclusive: both key off pend_valid_q.
        if (frame_wrap && pend_valid_q) begin
            act_d        = pend_q;
            pend_valid_d = 1'b0;
        end
        if (accept) begin
            pend_d.data  = wr.wr_data;
            pend_d.en    = wr.wr_en;
            pend_d.dp    = wr.wr_dp;
            pend_valid_d = 1'b1;
        end

        // Outputs are computed from next state so the registered pins line up with cnt.
        nib   = act_d.data[4*idx_d +: 4];
        show  = (state_d == ST_SHOW) && act_d.en[idx_d];
        seg_d = show ? ~(glyph(nib) | {7'b0, act_d.dp[idx_d]}) : 8'hFF;
        an_d  = show ? ~(NDIG'(1) << idx_d) : '1;
        fd_d  = frame_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            act_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            seg_q        <= 8'hFF;
            an_q         <= '1;
            fd_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            fd_q         <= fd_d;
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a frame-level reference model
// that derives slot, digit and frame boundaries from elapsed cycles.
module tb_seg_scan_ctrl;
    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * DIV;
    localparam logic [7:0] GLYPH [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                          8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      seg_out;
    logic [NDIG-1:0] an_out;
    logic            frame_done;

    seg_scan_if #(.NDIG(NDIG)) wif ();

    seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (wif.slave),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: elapsed cycles since reset plus two frame buffers.
    int              t;
    logic [15:0]     a_data, p_data;
    logic [NDIG-1:0] a_en, a_dp, p_en, p_dp;
    bit              p_v, m_fd, acc_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; a_data = '0; a_en = '0; a_dp = '0;
        p_data = '0; p_en = '0; p_dp = '0; p_v = 0; m_fd = 0; acc_last = 0;
    endtask

    task automatic model_step();
        bit acc;
        acc = wif.wr_valid && !p_v;
        t++;
        m_fd = (t % FRAME == 0);
        if (m_fd && p_v) begin
            a_data = p_data; a_en = p_en; a_dp = p_dp; p_v = 0;
        end
        if (acc) begin
            p_data = wif.wr_data; p_en = wif.wr_en; p_dp = wif.wr_dp; p_v = 1;
        end
        acc_last = acc;
    endtask

    task automatic check_outputs();
        int cnt, idx;
        bit show;
        logic [7:0]      e_seg;
        logic [NDIG-1:0] e_an;
        cnt  = t % DIV;
        idx  = (t / DIV) % NDIG;
        show = (cnt >= BLANK) && a_en[idx];
        e_seg = show ? ~(GLYPH[a_data[4*idx +: 4]] | {7'b0, a_dp[idx]}) : 8'hFF;
        e_an  = show ? ~(NDIG'(1) << idx) : '1;
        chk("seg_out",    32'(seg_out),       32'(e_seg));
        chk("an_out",     32'(an_out),        32'(e_an));
        chk("frame_done", 32'(frame_done),    32'(m_fd));
        chk("wr_ready",   32'(wif.wr_ready),  32'(!p_v));
    endtask

    task automatic new_frame(input bit valid);
        wif.wr_valid = valid;
        wif.wr_data  = 16'($urandom);
        wif.wr_en    = ($urandom % 2 == 0) ? '1 : NDIG'($urandom);
        wif.wr_dp    = NDIG'($urandom);
    endtask

    initial begin
        bit want_rst;
        int rst_hold;
        want_rst = 0;
        rst_hold = 0;
        wif.wr_valid = 0; wif.wr_data = '0; wif.wr_en = '0; wif.wr_dp = '0;
        rst = 1;
        #1 model_reset();
        check_outputs();
        repeat (3) begin
            @(negedge clk);
            check_outputs();
        end
        rst = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            if (!rst) model_step();
            @(negedge clk);
            check_outputs();

            if (cyc == 1500) want_rst = 1;
            if (want_rst && !rst && ((t / DIV) % NDIG == 2) && (t % DIV >= BLANK)) begin
                rst = 1;
                #1 model_reset();
                check_outputs();
                want_rst = 0;
                rst_hold = 3;
            end else if (rst) begin
                rst_hold--;
                if (rst_hold == 0) rst = 0;
            end

            if (cyc < 40) begin
                wif.wr_valid = 0;
            end else if (wif.wr_valid && !acc_last && ($urandom % 8 != 0)) begin
                // keep presenting the same frame while the pending buffer is full
            end else if (m_fd) begin
                new_frame($urandom % 2 == 0);
            end else begin
                new_frame($urandom % 24 == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
